// File: rtl/ex_pkg.sv
// Shared decode constants and enumerations for the RV32I multi-cycle execute stage.
package ex_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, ILL} alu_op_e;

   typedef enum logic {IDLE, SHIFT} state_e;

   function automatic logic is_shift_op(input alu_op_e op);
      return (op == SLL) || (op == SRL) || (op == SRA);
   endfunction

endpackage

// File: rtl/ex_stage_mc_if.sv
// Decode-side and writeback-side handshake bundle of the execute stage.
interface ex_stage_mc_if #(parameter int XLEN = 32);
   logic            flush_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [31:0]     inst_i;
   logic [31:0]     inst_addr_i;
   logic [XLEN-1:0] op1_i;
   logic [XLEN-1:0] op2_i;
   logic [4:0]      rd_addr_i;
   logic            rd_wen_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [4:0]      rd_addr_o;
   logic [XLEN-1:0] rd_data_o;
   logic            rd_wen_o;
   logic [31:0]     inst_addr_o;
   logic            illegal_o;
   logic            busy_o;

   modport master (
      output flush_i, in_valid_i, inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i, out_ready_i,
      input  in_ready_o, out_valid_o, rd_addr_o, rd_data_o, rd_wen_o, inst_addr_o, illegal_o, busy_o
   );

   modport slave (
      input  flush_i, in_valid_i, inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i, out_ready_i,
      output in_ready_o, out_valid_o, rd_addr_o, rd_data_o, rd_wen_o, inst_addr_o, illegal_o, busy_o
   );
endinterface

// File: rtl/ex_shifter_iter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle and holds its result
// (cnt at zero) while the output slot is still occupied.
module ex_shifter_iter
   import ex_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     start,
   input  alu_op_e                  op,
   input  logic [XLEN-1:0]          op1,
   input  logic [$clog2(XLEN)-1:0]  shamt,
   input  logic                     stall,
   output logic                     done,
   output logic                     busy,
   output logic [XLEN-1:0]          result
);
   localparam int            CW     = $clog2(XLEN);
   localparam logic [CW:0]   STEP_W = (CW+1)'(SHIFT_STEP);

   state_e          state_r;
   alu_op_e         op_r;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_next_s;
   logic [CW-1:0]   amt_s;
   logic [XLEN-1:0] work_r;
   logic [XLEN-1:0] work_next_s;
   logic            busy_r;

   // One step: shift by min(cnt, SHIFT_STEP); at cnt==0 the work value is frozen.
   always_comb begin
      if ({1'b0, cnt_r} > STEP_W) begin
         amt_s = STEP_W[CW-1:0];
      end else begin
         amt_s = cnt_r;
      end
      cnt_next_s = cnt_r - amt_s;
      case (op_r)
         SLL:     work_next_s = work_r << amt_s;
         SRL:     work_next_s = work_r >> amt_s;
         SRA:     work_next_s = $signed(work_r) >>> amt_s;
         default: work_next_s = work_r;
      endcase
   end

   assign done   = (state_r == SHIFT) && (cnt_next_s == {CW{1'b0}}) && !stall && !flush;
   assign busy   = busy_r;
   assign result = work_next_s;

   // Shift FSM with work/count registers; flush abandons an operation in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         op_r    <= ADD;
         cnt_r   <= {CW{1'b0}};
         work_r  <= {XLEN{1'b0}};
         busy_r  <= 1'b0;
      end else if (flush) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
         work_r  <= {XLEN{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= SHIFT;
                  op_r    <= op;
                  cnt_r   <= shamt;
                  work_r  <= op1;
                  busy_r  <= 1'b1;
               end
            end
            SHIFT: begin
               work_r <= work_next_s;
               cnt_r  <= cnt_next_s;
               if ((cnt_next_s == {CW{1'b0}}) && !stall) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/ex_stage_mc.sv
// RV32I OP/OP-IMM execute stage: single-cycle ALU for most operations, iterative
// shifter for non-zero shifts, one registered result slot toward writeback.
module ex_stage_mc
   import ex_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input logic          clk,
   input logic          rst,
   ex_stage_mc_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   function automatic alu_op_e decode_op(input logic [31:0] inst);
      alu_op_e op;
      op = ILL;
      case (inst[6:0])
         OPC_OP_IMM: begin
            case (inst[14:12])
               F3_ADD:  op = ADD;
               F3_SLT:  op = SLT;
               F3_SLTU: op = SLTU;
               F3_XOR:  op = XOR;
               F3_OR:   op = OR;
               F3_AND:  op = AND;
               F3_SLL:  op = (inst[31:26] == 6'b000000) ? SLL : ILL;
               F3_SR:   op = ({inst[31], inst[29:26]} == 5'b00000) ? (inst[30] ? SRA : SRL) : ILL;
               default: op = ILL;
            endcase
         end
         OPC_OP: begin
            case (inst[31:25])
               F7_BASE: begin
                  case (inst[14:12])
                     F3_ADD:  op = ADD;
                     F3_SLL:  op = SLL;
                     F3_SLT:  op = SLT;
                     F3_SLTU: op = SLTU;
                     F3_XOR:  op = XOR;
                     F3_SR:   op = SRL;
                     F3_OR:   op = OR;
                     F3_AND:  op = AND;
                     default: op = ILL;
                  endcase
               end
               F7_ALT: begin
                  case (inst[14:12])
                     F3_ADD:  op = SUB;
                     F3_SR:   op = SRA;
                     default: op = ILL;
                  endcase
               end
               default: op = ILL;
            endcase
         end
         default: op = ILL;
      endcase
      return op;
   endfunction

   alu_op_e         op_s;
   logic            legal_s;
   logic [CW-1:0]   shamt_s;
   logic            slot_free_s;
   logic            in_ready_s;
   logic            accept_s;
   logic            start_s;
   logic            wen_s;
   logic [XLEN-1:0] alu_s;
   logic            sh_done_s;
   logic            sh_busy_s;
   logic [XLEN-1:0] sh_result_s;
   logic            unused_s;

   logic            out_valid_r;
   logic [4:0]      rd_addr_r;
   logic [XLEN-1:0] rd_data_r;
   logic            rd_wen_r;
   logic [31:0]     inst_addr_r;
   logic            illegal_r;
   logic [4:0]      meta_rd_r;
   logic            meta_wen_r;
   logic [31:0]     meta_addr_r;

   assign op_s        = decode_op(bus.inst_i);
   assign legal_s     = (op_s != ILL);
   assign shamt_s     = bus.op2_i[CW-1:0];
   assign slot_free_s = !out_valid_r || bus.out_ready_i;
   assign in_ready_s  = !sh_busy_s && !bus.flush_i && slot_free_s;
   assign accept_s    = bus.in_valid_i && in_ready_s;
   assign start_s     = accept_s && is_shift_op(op_s) && (shamt_s != {CW{1'b0}});
   assign wen_s       = bus.rd_wen_i && legal_s && (bus.rd_addr_i != 5'd0);
   assign unused_s    = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

   // Single-cycle ALU; a zero-amount shift passes op1 through unchanged.
   always_comb begin
      case (op_s)
         ADD:     alu_s = bus.op1_i + bus.op2_i;
         SUB:     alu_s = bus.op1_i - bus.op2_i;
         SLT:     alu_s = {{(XLEN-1){1'b0}}, ($signed(bus.op1_i) < $signed(bus.op2_i))};
         SLTU:    alu_s = {{(XLEN-1){1'b0}}, (bus.op1_i < bus.op2_i)};
         XOR:     alu_s = bus.op1_i ^ bus.op2_i;
         OR:      alu_s = bus.op1_i | bus.op2_i;
         AND:     alu_s = bus.op1_i & bus.op2_i;
         SLL:     alu_s = bus.op1_i;
         SRL:     alu_s = bus.op1_i;
         SRA:     alu_s = bus.op1_i;
         default: alu_s = {XLEN{1'b0}};
      endcase
   end

   ex_shifter_iter #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_shifter (
      .clk    (clk),
      .rst    (rst),
      .flush  (bus.flush_i),
      .start  (start_s),
      .op     (op_s),
      .op1    (bus.op1_i),
      .shamt  (shamt_s),
      .stall  (!slot_free_s),
      .done   (sh_done_s),
      .busy   (sh_busy_s),
      .result (sh_result_s)
   );

   // Destination metadata captured at shift start, replayed when the shifter finishes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_rd_r   <= 5'd0;
         meta_wen_r  <= 1'b0;
         meta_addr_r <= 32'd0;
      end else if (start_s) begin
         meta_rd_r   <= bus.rd_addr_i;
         meta_wen_r  <= wen_s;
         meta_addr_r <= bus.inst_addr_i;
      end
   end

   // Output slot: flush wins, then shifter completion, then direct completion, then drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         rd_addr_r   <= 5'd0;
         rd_data_r   <= {XLEN{1'b0}};
         rd_wen_r    <= 1'b0;
         inst_addr_r <= 32'd0;
         illegal_r   <= 1'b0;
      end else if (bus.flush_i) begin
         out_valid_r <= 1'b0;
      end else if (sh_done_s) begin
         out_valid_r <= 1'b1;
         rd_addr_r   <= meta_rd_r;
         rd_data_r   <= sh_result_s;
         rd_wen_r    <= meta_wen_r;
         inst_addr_r <= meta_addr_r;
         illegal_r   <= 1'b0;
      end else if (accept_s && !start_s) begin
         out_valid_r <= 1'b1;
         rd_addr_r   <= legal_s ? bus.rd_addr_i : 5'd0;
         rd_data_r   <= legal_s ? alu_s : {XLEN{1'b0}};
         rd_wen_r    <= wen_s;
         inst_addr_r <= bus.inst_addr_i;
         illegal_r   <= !legal_s;
      end else if (bus.out_ready_i) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.in_ready_o  = in_ready_s;
   assign bus.out_valid_o = out_valid_r;
   assign bus.rd_addr_o   = rd_addr_r;
   assign bus.rd_data_o   = rd_data_r;
   assign bus.rd_wen_o    = rd_wen_r;
   assign bus.inst_addr_o = inst_addr_r;
   assign bus.illegal_o   = illegal_r;
   assign bus.busy_o      = sh_busy_s;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc (XLEN=32, SHIFT_STEP=4) with directed vectors.
module tb_ex_stage_mc;
   import ex_pkg::*;

   localparam int XLEN = 32;
   localparam int STEP = 4;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wen;
      logic        ill;
      logic [31:0] iaddr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] pc = 32'h0000_1000;
   exp_t        exp_q[$];
   exp_t        mon_e;

   always #5 clk = ~clk;

   ex_stage_mc_if #(.XLEN(XLEN)) bus ();

   ex_stage_mc #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
      return {imm, 5'd1, f3, rd, OPC_OP_IMM};
   endfunction

   function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, OPC_OP};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offer one instruction and push its expected result once it is accepted.
   task automatic issue(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] ed, input logic [4:0] erd,
                        input logic ewen, input logic eill);
      exp_t e;
      logic acc;
      logic acc_now;
      bus.inst_i      = inst;
      bus.inst_addr_i = pc;
      bus.op1_i       = a;
      bus.op2_i       = b;
      bus.rd_addr_i   = rd;
      bus.rd_wen_i    = 1'b1;
      bus.in_valid_i  = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc_now = bus.in_ready_o;
         @(posedge clk);
         if (acc_now) acc = 1'b1;
         #1;
      end
      bus.in_valid_i = 1'b0;
      if (acc) begin
         e.data = ed; e.rd = erd; e.wen = ewen; e.ill = eill; e.iaddr = pc;
         exp_q.push_back(e);
      end else begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready never high expected acceptance of inst %h", inst);
      end
      pc = pc + 32'd4;
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: a result transfers on the next edge whenever valid and ready are both high.
   always @(negedge clk) begin
      if (!rst && bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got data=%h rd=%0d addr=%h expected no result", bus.rd_data_o, bus.rd_addr_o, bus.inst_addr_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.rd_data_o !== mon_e.data || bus.rd_addr_o !== mon_e.rd || bus.rd_wen_o !== mon_e.wen ||
                bus.illegal_o !== mon_e.ill || bus.inst_addr_o !== mon_e.iaddr) begin
               errors++;
               $display("FAIL result@%h: got data=%h rd=%0d wen=%b ill=%b addr=%h expected data=%h rd=%0d wen=%b ill=%b addr=%h",
                        mon_e.iaddr, bus.rd_data_o, bus.rd_addr_o, bus.rd_wen_o, bus.illegal_o, bus.inst_addr_o,
                        mon_e.data, mon_e.rd, mon_e.wen, mon_e.ill, mon_e.iaddr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic ir_bad;
      bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.inst_i = 32'd0; bus.inst_addr_i = 32'd0;
      bus.op1_i = 32'd0; bus.op2_i = 32'd0; bus.rd_addr_i = 5'd0; bus.rd_wen_i = 1'b0; bus.out_ready_i = 1'b1;

      #2;
      check("reset_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
      check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
      check("reset_outputs", {bus.rd_data_o[15:0], 3'd0, bus.rd_addr_o, 6'd0, bus.rd_wen_o, bus.illegal_o}, 32'd0);
      check("reset_inst_addr", bus.inst_addr_o, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
      @(posedge clk); #1;

      // Basic ALU and compares
      issue(itype(12'hFFF, F3_ADD, 5'd3), 32'd5, 32'hFFFF_FFFF, 5'd3, 32'd4, 5'd3, 1'b1, 1'b0);
      check("addi_latency_valid", {31'd0, bus.out_valid_o}, 32'd1);
      issue(rtype(F7_ALT, F3_ADD, 5'd4), 32'd10, 32'd3, 5'd4, 32'd7, 5'd4, 1'b1, 1'b0);
      issue(rtype(F7_BASE, F3_SLT, 5'd5), 32'h8000_0000, 32'd1, 5'd5, 32'd1, 5'd5, 1'b1, 1'b0);
      issue(rtype(F7_BASE, F3_SLTU, 5'd0), 32'h8000_0000, 32'd1, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      issue(itype(12'h0F0, F3_XOR, 5'd6), 32'h0000_F0F0, 32'h0000_0FF0, 5'd6, 32'h0000_FF00, 5'd6, 1'b1, 1'b0);
      issue(itype(12'h0F0, F3_OR, 5'd7), 32'h0000_0F00, 32'h0000_00F0, 5'd7, 32'h0000_0FF0, 5'd7, 1'b1, 1'b0);
      issue(itype(12'hF0F, F3_AND, 5'd8), 32'hFFFF_FFF0, 32'h0000_FF0F, 5'd8, 32'h0000_FF00, 5'd8, 1'b1, 1'b0);
      issue(itype(12'hFFF, F3_SLTU, 5'd9), 32'd1, 32'hFFFF_FFFF, 5'd9, 32'd1, 5'd9, 1'b1, 1'b0);
      drain();

      // Long arithmetic shift: eight SHIFT cycles, decode stalled throughout
      issue(rtype(F7_ALT, F3_SR, 5'd10), 32'h8000_0000, 32'd31, 5'd10, 32'hFFFF_FFFF, 5'd10, 1'b1, 1'b0);
      n = 0; ir_bad = 1'b0;
      while (bus.busy_o === 1'b1 && n < 20) begin
         if (bus.in_ready_o !== 1'b0) ir_bad = 1'b1;
         n++;
         @(posedge clk); #1;
      end
      check("sra31_busy_cycles", 32'(n), 32'd8);
      check("sra31_in_ready_low", {31'd0, ir_bad}, 32'd0);
      check("sra31_valid_after", {31'd0, bus.out_valid_o}, 32'd1);
      drain();

      issue(itype({7'b0000000, 5'd4}, F3_SLL, 5'd11), 32'd1, 32'd4, 5'd11, 32'd16, 5'd11, 1'b1, 1'b0);
      issue(itype({7'b0000000, 5'd5}, F3_SR, 5'd12), 32'h8000_0000, 32'd5, 5'd12, 32'h0400_0000, 5'd12, 1'b1, 1'b0);
      issue(itype({7'b0100000, 5'd1}, F3_SR, 5'd13), 32'h8000_0000, 32'h0000_0401, 5'd13, 32'hC000_0000, 5'd13, 1'b1, 1'b0);
      issue(rtype(F7_BASE, F3_SLL, 5'd15), 32'd1, 32'h0000_0021, 5'd15, 32'd2, 5'd15, 1'b1, 1'b0);
      drain();
      issue(rtype(F7_BASE, F3_SLL, 5'd14), 32'd3, 32'h0000_0020, 5'd14, 32'd3, 5'd14, 1'b1, 1'b0);
      check("sll0_one_cycle_valid", {31'd0, bus.out_valid_o}, 32'd1);
      check("sll0_no_busy", {31'd0, bus.busy_o}, 32'd0);
      drain();

      // Back-pressure: writeback stalls for five cycles during three adds
      bus.out_ready_i = 1'b0;
      fork
         begin
            issue(rtype(F7_BASE, F3_ADD, 5'd16), 32'd1, 32'd1, 5'd16, 32'd2, 5'd16, 1'b1, 1'b0);
            issue(rtype(F7_BASE, F3_ADD, 5'd17), 32'd2, 32'd2, 5'd17, 32'd4, 5'd17, 1'b1, 1'b0);
            issue(rtype(F7_BASE, F3_ADD, 5'd18), 32'd3, 32'd3, 5'd18, 32'd6, 5'd18, 1'b1, 1'b0);
         end
         begin
            @(posedge clk); #1;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               check("bp_first_held", {bus.out_valid_o, bus.in_ready_o, 25'd0, bus.rd_addr_o}, {1'b1, 1'b0, 25'd0, 5'd16});
               check("bp_first_data", bus.rd_data_o, 32'd2);
            end
            @(posedge clk); #1;
            bus.out_ready_i = 1'b1;
         end
      join
      drain();

      // Flush in the middle of a shift (count at 12)
      issue(itype({7'b0000000, 5'd20}, F3_SLL, 5'd19), 32'd1, 32'd20, 5'd19, 32'h0010_0000, 5'd19, 1'b1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.flush_i = 1'b1;
      #1;
      check("flush_blocks_ready", {31'd0, bus.in_ready_o}, 32'd0);
      @(posedge clk); #1;
      check("flush_idle_busy", {31'd0, bus.busy_o}, 32'd0);
      check("flush_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
      void'(exp_q.pop_back());
      bus.in_valid_i = 1'b1;
      bus.inst_i = itype(12'd1, F3_ADD, 5'd20);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      bus.flush_i = 1'b0;
      repeat (3) @(posedge clk); #1;
      issue(itype(12'hFFE, F3_ADD, 5'd9), 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd5, 5'd9, 1'b1, 1'b0);
      drain();

      // Illegal encodings
      issue(rtype(7'b0000001, F3_ADD, 5'd10), 32'd5, 32'd6, 5'd10, 32'd0, 5'd0, 1'b0, 1'b1);
      check("illegal_flag", {31'd0, bus.illegal_o}, 32'd1);
      issue(rtype(F7_ALT, F3_XOR, 5'd11), 32'd5, 32'd6, 5'd11, 32'd0, 5'd0, 1'b0, 1'b1);
      issue({20'h12345, 5'd12, 7'b0110111}, 32'd5, 32'd6, 5'd12, 32'd0, 5'd0, 1'b0, 1'b1);
      issue(itype({7'b0000010, 5'd3}, F3_SLL, 5'd13), 32'd1, 32'd3, 5'd13, 32'd0, 5'd0, 1'b0, 1'b1);
      drain();

      // Reset asserted in the middle of a shift
      issue(rtype(F7_ALT, F3_SR, 5'd21), 32'h8000_0000, 32'd31, 5'd21, 32'hFFFF_FFFF, 5'd21, 1'b1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_async_busy_valid", {30'd0, bus.busy_o, bus.out_valid_o}, 32'd0);
      check("rst_async_outputs", {bus.rd_data_o[15:0], 3'd0, bus.rd_addr_o, 6'd0, bus.rd_wen_o, bus.illegal_o}, 32'd0);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
      @(posedge clk); #1;
      issue(rtype(F7_BASE, F3_ADD, 5'd22), 32'd40, 32'd2, 5'd22, 32'd42, 5'd22, 1'b1, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised multi-cycle execute stage for the RV32I integer core, sitting between decode (operands already read and immediates sign-extended) and writeback. Covers the full OP-IMM and OP ALU sets: add/sub, compare, logic and shifts. Results are registered, and both sides use valid/ready handshakes. Shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle, so the stage can stall decode and be back-pressured by writeback.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- SHIFT_STEP, 1: bits shifted per iteration; power of two, 1..XLEN.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous kill of in-flight and held work.
- in_valid_i  in  1  decode offers an instruction.
- in_ready_o  out  1  stage accepts this cycle.
- inst_i  in  32  instruction word.
- inst_addr_i  in  32  instruction address, carried through.
- op1_i  in  XLEN  rs1 value.
- op2_i  in  XLEN  rs2 value or sign-extended imm.
- rd_addr_i  in  5  destination register.
- rd_wen_i  in  1  decode write enable.
- out_valid_o  out  1  result held for writeback.
- out_ready_i  in  1  writeback consumes.
- rd_addr_o  out  5  destination.
- rd_data_o  out  XLEN  result.
- rd_wen_o  out  1  write enable, already qualified.
- inst_addr_o  out  32  address of the result's instruction.
- illegal_o  out  1  result slot is an unsupported encoding.
- busy_o  out  1  shifter iterating.

## Operation
- Opcode 0010011, funct3:
  - 000 addi; 010 slti (signed <); 011 sltiu; 100 xori; 110 ori; 111 andi.
  - 001 slli, legal only when inst[31:26]=0.
  - 101 srli/srai, selected by inst[30]; other inst[31:26] bits must be 0.
- Opcode 0110011:
  - funct7 0000000 selects add, sll, slt, sltu, xor, srl, or, and by funct3.
  - funct7 0100000 is legal only with funct3 000 (sub = op1-op2) or 101 (sra).
  - Any other funct7 is illegal.
- Arithmetic: modulo 2^XLEN, no overflow flag. slt/sltu results are zero-extended 0/1. Shift amount is op2[$clog2(XLEN)-1:0]; sra replicates op1[XLEN-1].
- Illegal or other opcodes: result slot carries illegal_o=1, rd_wen_o=0, rd_addr_o=0, rd_data_o=0.
- rd_wen_o = rd_wen_i && legal && rd_addr_i!=0.
- States:
  - IDLE → SHIFT on accept of a shift with shamt≠0: load work=op1, cnt=shamt.
  - SHIFT: each edge shifts work by min(cnt,SHIFT_STEP) and decrements cnt by the same amount.
  - SHIFT → IDLE on the edge where cnt reaches 0 and the output slot is free (!out_valid_o or out_ready_i). The result is written on that edge.
  - If the slot is occupied, SHIFT holds with cnt=0 and work unchanged.
- All other legal and illegal instructions, including shamt=0, complete directly from IDLE.
- in_ready_o = state==IDLE && !flush_i && (!out_valid_o || out_ready_i).

## Timing
- Reset state: IDLE, cnt=0, work=0. All registered outputs are 0 (out_valid_o, rd_*_o, inst_addr_o, illegal_o, busy_o), so in_ready_o=1 in the first cycle after rst deasserts. An rst assertion mid-shift discards the operation immediately.
- Non-shift latency: accepted in cycle T → out_valid_o=1 from T+1.
- Shift latency: max(1, ceil(shamt/SHIFT_STEP)) cycles plus any back-pressure stall; busy_o=1 in every SHIFT cycle.
- Output handshake: data is held stable while out_valid_o && !out_ready_i.
  - Drain without refill clears out_valid_o on the next edge.
  - Simultaneous drain and new completion loads the new result with no bubble.
- flush_i on an edge:
  - Clears out_valid_o and returns to IDLE.
  - Discards any shift in progress.
  - Blocks acceptance of any input that cycle.
  - Takes priority over every other event except rst.

## Structure
- Package ex_pkg holds:
  - opcode constants OPC_OP_IMM and OPC_OP;
  - funct3 and funct7 constants;
  - alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, ILL);
  - state_e enum (IDLE, SHIFT).
- Sub-module ex_shifter_iter (parameters XLEN, SHIFT_STEP) owns work, cnt and the step logic, with start/done/stall ports.
- The top level holds the decode-to-alu_op function, the single-cycle ALU, the output register and the handshake.

## Test plan
- Basic ALU: addi op1=5, op2=0xFFFFFFFF, rd=3 → rd_data_o=4, rd_wen_o=1, out_valid_o the cycle after acceptance. sub op1=10, op2=3 → 7.
- Compare: slt 0x80000000 vs 1 → 1; sltu same operands → 0. Any write with rd=0 → rd_wen_o=0.
- Shifts, SHIFT_STEP=4:
  - sra 0x80000000 by 31 → 0xFFFFFFFF after 8 cycles, busy_o high for 8 cycles, in_ready_o low throughout.
  - sll by 0 → 1-cycle result.
- Back-pressure: out_ready_i held 0 for 5 cycles during three back-to-back adds → first result stable, second stalls, in_ready_o=0; release → results in order with no loss or duplication.
- Flush: flush_i mid-shift (cnt=12) → IDLE next cycle, out_valid_o=0, no result emitted; a following addi completes normally.
- Illegal/reset: OP with funct7=0000001 → illegal_o=1, rd_wen_o=0. rst asserted mid-shift → all outputs 0 asynchronously, in_ready_o=1 after release.
